// File: rtl/instruction_loader.sv
// Assembles UART bytes (MSB first) into 32-bit words and writes them to instruction memory.
// Optional trailing XOR checksum byte is enabled with `define INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int unsigned     SIZE            = 32,
  parameter int unsigned     MAX_INSTRUCTION = 64,
  parameter int unsigned     ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter logic [SIZE-1:0] HALT_WORD       = 32'hFFFF_FFFF,
  parameter int unsigned     TIMEOUT_CYCLES  = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_loading,
  output logic                  o_done,
  output logic [1:0]            o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_INSTRUCTION - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DONE, ERROR} state_t;
`endif

  state_t                state, state_next;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [TW-1:0]         tcount;
  logic [SIZE-1:0]       shift_reg;
  logic [SIZE-1:0]       word_c;
  logic [1:0]            error_next;
  logic                  start_load;
  logic                  load_accept;
  logic                  word_done;
  logic                  tmo_expire;
  logic                  loading_next;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  // Next-state and termination decode
  always_comb begin
    state_next   = state;
    error_next   = o_error;
    start_load   = 1'b0;
    load_accept  = 1'b0;
    word_done    = 1'b0;
    word_c       = {shift_reg[SIZE-9:0], i_rx_data};
    tmo_expire   = (TIMEOUT_CYCLES != 0) && (tcount == TW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          start_load = 1'b1;
          error_next = ERR_NONE;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (i_rx_valid) begin
          load_accept = 1'b1;
          if (byte_idx == 2'd3) begin
            word_done = 1'b1;
            if (word_c == HALT_WORD) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
              state_next = CHECK;
`else
              state_next = DONE;
`endif
            end else if (addr == LAST_ADDR) begin
              state_next = ERROR;
              error_next = ERR_OVERFLOW;
            end
          end
        end else if (tmo_expire) begin
          state_next = ERROR;
          error_next = ERR_TIMEOUT;
        end
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      CHECK: begin
        if (i_rx_valid) begin
          if (i_rx_data == csum) begin
            state_next = DONE;
          end else begin
            state_next = ERROR;
            error_next = ERR_CHECKSUM;
          end
        end else if (tmo_expire) begin
          state_next = ERROR;
          error_next = ERR_TIMEOUT;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    loading_next = (state_next == LOAD) || (state_next == CHECK);
`else
    loading_next = (state_next == LOAD);
`endif
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state               <= IDLE;
      byte_idx            <= '0;
      addr                <= '0;
      tcount              <= '0;
      shift_reg           <= '0;
      o_inst_write_enable <= 1'b0;
      o_write_addr        <= '0;
      o_write_data        <= '0;
      o_loading           <= 1'b0;
      o_done              <= 1'b0;
      o_error             <= ERR_NONE;
      o_word_count        <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      csum                <= '0;
`endif
    end else begin
      state               <= state_next;
      o_inst_write_enable <= 1'b0;
      o_loading           <= loading_next;
      o_done              <= (state_next == DONE);
      o_error             <= error_next;
      if (start_load) begin
        byte_idx     <= '0;
        addr         <= '0;
        tcount       <= '0;
        shift_reg    <= '0;
        o_word_count <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end else if (loading_next || state != state_next) begin
        // Idle-cycle counter restarts on every received byte while loading
        if (i_rx_valid) tcount <= '0;
        else            tcount <= tcount + TW'(1);
      end
      if (load_accept) begin
        shift_reg <= word_c;
        byte_idx  <= byte_idx + 2'd1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum      <= csum ^ i_rx_data;
`endif
      end
      if (word_done) begin
        o_inst_write_enable <= 1'b1;
        o_write_data        <= word_c;
        o_write_addr        <= addr;
        addr                <= addr + ADDR_WIDTH'(1);
        o_word_count        <= o_word_count + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader (MAX_INSTRUCTION=4, TIMEOUT_CYCLES=50).
// Honors INSTRUCTION_LOADER_CHECKSUM_EN by sending the trailing checksum byte after halt words.
module tb_instruction_loader;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          loading;
  logic          done;
  logic [1:0]    err;
  logic [AW:0]   wcount;

  int nvec = 0;
  int nerr = 0;

  logic [AW-1:0] qa[$];
  logic [31:0]   qd[$];

  instruction_loader #(
    .MAX_INSTRUCTION(4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (start),
    .i_rx_data          (rx_data),
    .i_rx_valid         (rx_valid),
    .o_inst_write_enable(we),
    .o_write_addr       (waddr),
    .o_write_data       (wdata),
    .o_loading          (loading),
    .o_done             (done),
    .o_error            (err),
    .o_word_count       (wcount)
  );

  always #5 clk = ~clk;

  // Record every cycle the write strobe is seen high
  always @(negedge clk) begin
    if (we) begin
      qa.push_back(waddr);
      qd.push_back(wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Halt word, then the checksum byte when that feature is built in
  task automatic send_halt(input logic [7:0] xsum);
    send_word(32'hFFFF_FFFF);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    send_byte(xsum);
`else
    if (xsum === 8'hxx) $display("unexpected checksum argument");
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_write(input string name, input int idx, input logic [AW-1:0] ea, input logic [31:0] ed);
    logic [AW-1:0] a;
    logic [31:0]   d;
    a = (qa.size() > idx) ? qa[idx] : 'x;
    d = (qd.size() > idx) ? qd[idx] : 'x;
    nvec++;
    if (a !== ea || d !== ed) begin
      nerr++;
      $display("FAIL %s: write %0d got addr %0d data %h, want addr %0d data %h", name, idx, a, d, ea, ed);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({we, waddr, wdata, loading, done, err, wcount} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h ld=%b dn=%b err=%b cnt=%0d, want all 0",
               we, waddr, wdata, loading, done, err, wcount);
    end
  endtask

  task automatic test_basic();
    qa.delete(); qd.delete();
    pulse_start();
    nvec++;
    if (loading !== 1'b1) begin nerr++; $display("FAIL basic_loading: got %b want 1", loading); end
    send_word(32'h0000_0020);
    send_halt(8'h20);
    repeat (3) @(negedge clk);
    nvec++;
    if (qa.size() != 2) begin nerr++; $display("FAIL basic_nwrites: got %0d want 2", qa.size()); end
    check_write("basic", 0, 2'd0, 32'h0000_0020);
    check_write("basic", 1, 2'd1, 32'hFFFF_FFFF);
    nvec++;
    if ({done, loading, err, wcount} !== {1'b1, 1'b0, 2'b00, 3'd2}) begin
      nerr++;
      $display("FAIL basic_status: got dn=%b ld=%b err=%b cnt=%0d want dn=1 ld=0 err=0 cnt=2", done, loading, err, wcount);
    end
    nvec++;
    if ({we, waddr, wdata} !== {1'b0, 2'd1, 32'hFFFF_FFFF}) begin
      nerr++;
      $display("FAIL basic_hold: got we=%b addr=%0d data=%h want we=0 addr=1 data=ffffffff", we, waddr, wdata);
    end
  endtask

  task automatic test_restart_and_ignore();
    qa.delete(); qd.delete();
    pulse_start();
    nvec++;
    if ({done, wcount, loading} !== {1'b0, 3'd0, 1'b1}) begin
      nerr++;
      $display("FAIL restart_clear: got dn=%b cnt=%0d ld=%b want dn=0 cnt=0 ld=1", done, wcount, loading);
    end
    send_word(32'h0102_0304);
    pulse_start();
    nvec++;
    if ({wcount, loading} !== {3'd1, 1'b1}) begin
      nerr++;
      $display("FAIL start_ignored: got cnt=%0d ld=%b want cnt=1 ld=1", wcount, loading);
    end
    send_word(32'h0506_0708);
    send_halt(8'h08);
    @(negedge clk);
    check_write("restart", 0, 2'd0, 32'h0102_0304);
    check_write("restart", 1, 2'd1, 32'h0506_0708);
    check_write("restart", 2, 2'd2, 32'hFFFF_FFFF);
    nvec++;
    if ({done, wcount} !== {1'b1, 3'd3}) begin
      nerr++;
      $display("FAIL restart_done: got dn=%b cnt=%0d want dn=1 cnt=3", done, wcount);
    end
  endtask

  task automatic test_overflow();
    qa.delete(); qd.delete();
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'h11);
    repeat (2) @(negedge clk);
    nvec++;
    if (qa.size() != 4) begin nerr++; $display("FAIL ovf_nwrites: got %0d want 4", qa.size()); end
    for (int i = 0; i < 4; i++) check_write("ovf", i, AW'(i), 32'h1111_1111);
    nvec++;
    if ({err, wcount, done, loading} !== {2'b01, 3'd4, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL ovf_status: got err=%b cnt=%0d dn=%b ld=%b want err=01 cnt=4 dn=0 ld=0", err, wcount, done, loading);
    end
  endtask

  task automatic test_halt_last_slot();
    qa.delete(); qd.delete();
    pulse_start();
    nvec++;
    if (err !== 2'b00) begin nerr++; $display("FAIL lastslot_errclr: got %b want 00", err); end
    for (int i = 0; i < 12; i++) send_byte(8'h11);
    send_halt(8'h00);
    @(negedge clk);
    check_write("lastslot", 3, 2'd3, 32'hFFFF_FFFF);
    nvec++;
    if ({done, err, wcount} !== {1'b1, 2'b00, 3'd4}) begin
      nerr++;
      $display("FAIL lastslot_status: got dn=%b err=%b cnt=%0d want dn=1 err=00 cnt=4", done, err, wcount);
    end
  endtask

  task automatic test_timeout();
    int k;
    qa.delete(); qd.delete();
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    k = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (err == 2'b10) begin k = i; break; end
    end
    nvec++;
    if (k != 50) begin nerr++; $display("FAIL timeout_latency: got %0d cycles want 50", k); end
    nvec++;
    if ({qa.size() == 0, loading, done} !== {1'b1, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL timeout_status: got writes=%0d ld=%b dn=%b want writes=0 ld=0 dn=0", qa.size(), loading, done);
    end
  endtask

  task automatic test_timeout_race();
    qa.delete(); qd.delete();
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (48) @(negedge clk);
    send_byte(8'hCC);
    nvec++;
    if ({err, loading} !== {2'b00, 1'b1}) begin
      nerr++;
      $display("FAIL race_byte_wins: got err=%b ld=%b want err=00 ld=1", err, loading);
    end
    send_byte(8'hDD);
    send_halt(8'h00);
    @(negedge clk);
    check_write("race", 0, 2'd0, 32'hAABB_CCDD);
    nvec++;
    if ({done, err} !== {1'b1, 2'b00}) begin
      nerr++;
      $display("FAIL race_done: got dn=%b err=%b want dn=1 err=00", done, err);
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({we, waddr, wdata, loading, done, err, wcount} !== '0) begin
      nerr++;
      $display("FAIL midreset_outputs: got we=%b addr=%0d data=%h ld=%b dn=%b err=%b cnt=%0d want all 0",
               we, waddr, wdata, loading, done, err, wcount);
    end
    qa.delete(); qd.delete();
    pulse_start();
    send_word(32'h1234_5678);
    send_halt(8'h08);
    @(negedge clk);
    check_write("midreset", 0, 2'd0, 32'h1234_5678);
    nvec++;
    if ({done, wcount} !== {1'b1, 3'd2}) begin
      nerr++;
      $display("FAIL midreset_done: got dn=%b cnt=%0d want dn=1 cnt=2", done, wcount);
    end
  endtask

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_word(32'h0000_0020);
    send_word(32'hFFFF_FFFF);
    nvec++;
    if ({loading, done} !== {1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL csum_check_state: got ld=%b dn=%b want ld=1 dn=0", loading, done);
    end
    send_byte(8'h20);
    nvec++;
    if ({done, err} !== {1'b1, 2'b00}) begin
      nerr++;
      $display("FAIL csum_good: got dn=%b err=%b want dn=1 err=00", done, err);
    end
    pulse_start();
    send_word(32'h0000_0020);
    send_word(32'hFFFF_FFFF);
    send_byte(8'h21);
    nvec++;
    if ({done, err, loading} !== {1'b0, 2'b11, 1'b0}) begin
      nerr++;
      $display("FAIL csum_bad: got dn=%b err=%b ld=%b want dn=0 err=11 ld=0", done, err, loading);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_restart_and_ignore();
    test_overflow();
    test_halt_last_slot();
    test_timeout();
    test_timeout_race();
    test_mid_reset();
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Upstream feeder of the instruction fetch stage's program-memory write port.
- Takes a byte stream from the debug UART receiver and assembles each group of 4 bytes into a 32-bit instruction word, MSB first.
- Issues one-cycle write strobes (enable, address, data) into instruction memory at sequential addresses.
- Load ends on a halt word, on memory overflow, or on an inter-byte timeout.

Parameters:
- SIZE, 32, instruction word width; fixed at 4 bytes.
- MAX_INSTRUCTION, 64, instruction memory depth in words.
- ADDR_WIDTH, $clog2(MAX_INSTRUCTION), write address width.
- HALT_WORD, 32'hFFFFFFFF, word that terminates a load; it is written to memory.
- TIMEOUT_CYCLES, 100000, maximum cycles between accepted bytes while loading; 0 disables the timeout.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  begin a new load; sampled in IDLE, DONE and ERROR.
- i_rx_data  input  8  received byte.
- i_rx_valid  input  1  i_rx_data valid this cycle; single-cycle pulse per byte.
- o_inst_write_enable  output  1  instruction memory write strobe.
- o_write_addr  output  ADDR_WIDTH  write address.
- o_write_data  output  SIZE  write data.
- o_loading  output  1  high while in LOAD (or CHECK); used to hold the CPU pipeline.
- o_done  output  1  load completed successfully.
- o_error  output  2  00 none, 01 overflow, 10 timeout, 11 checksum mismatch.
- o_word_count  output  ADDR_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, including o_write_data and o_write_addr.
  - Byte index, address counter, timeout counter and shift register are cleared.
- Reset mid-load abandons the partial word. No write is issued for it.
- States: IDLE, LOAD, CHECK (only with CHECKSUM_EN), DONE, ERROR.
- Entering LOAD:
  - IDLE, DONE or ERROR with i_start=1 -> LOAD on the next edge.
  - On entry, byte index, address, o_word_count, o_error and the timeout counter are cleared, and o_done is cleared.
  - i_start is ignored while in LOAD or CHECK.
- Byte accept:
  - A byte is accepted on an edge where state is LOAD and i_rx_valid=1.
  - Accepted bytes shift into the word MSB-first: byte 0 lands in bits [31:24].
  - Bytes are ignored in every other state.
- Word write:
  - On the edge accepting byte 3, the block registers o_inst_write_enable=1, o_write_data=assembled word and o_write_addr=address counter.
  - On the same edge the address counter and o_word_count increment.
  - o_inst_write_enable is high for exactly one cycle. On all other cycles it is 0, and o_write_addr/o_write_data hold their last values.
- Termination, evaluated on the same edge as the write:
  - Word == HALT_WORD -> DONE, or CHECK when CHECKSUM_EN is defined.
  - Else, if the written address was MAX_INSTRUCTION-1 -> ERROR with o_error=01; the word is still written.
  - Else stay in LOAD.
  - When a halt word lands in the last slot, the halt rule takes priority.
- Timeout:
  - The counter runs in LOAD and CHECK and is cleared on every accepted byte.
  - When it reaches TIMEOUT_CYCLES (nonzero) -> ERROR with o_error=10.
  - No write is issued for a partial word.
  - If a byte arrives on the same edge the timeout is reached, the byte wins.
- o_loading is 1 in LOAD and CHECK, 0 otherwise.
- o_done is 1 only in DONE.
- o_error holds its value until the next start or reset.

Optional Feature:
- Macro: INSTRUCTION_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR of all accepted bytes, including the halt word bytes, is accumulated during LOAD.
  - After the halt word the block enters CHECK and waits for one more byte.
  - Byte equals the accumulated XOR -> DONE; otherwise -> ERROR with o_error=11.
  - The timeout applies in CHECK.
- When undefined:
  - No CHECK state and no accumulator.
  - Halt word goes directly to DONE; error code 11 is never produced.

Test Plan:
- Basic load: reset, i_start, bytes 00 00 00 20 FF FF FF FF -> exactly two one-cycle writes, (addr 0, 0x00000020) then (addr 1, 0xFFFFFFFF); o_done=1, o_word_count=2, o_loading=0.
- Overflow: MAX_INSTRUCTION=4, send 16 bytes of 0x11 -> 4 writes at addrs 0..3 of 0x11111111; state ERROR, o_error=01, o_word_count=4.
- Timeout: TIMEOUT_CYCLES=50, send AA BB then idle -> o_error=10 exactly 50 cycles after the second byte; no write strobe.
- Timeout race: TIMEOUT_CYCLES=50, deliver a byte on the 50th idle cycle -> byte accepted, no error.
- Mid-load reset: after 3 bytes, pulse i_rst for 1 cycle -> all outputs 0; restart, send 12 34 56 78 FF FF FF FF -> first write is addr 0, 0x12345678 (no leftover bytes).
- Restart and start-ignore:
  - i_start asserted during LOAD -> ignored; counts are not cleared.
  - i_start from DONE -> o_done=0, o_word_count=0; the new load writes from addr 0.
- Checksum (macro defined): send 00 00 00 20 FF FF FF FF then 0x20 -> DONE; repeat with trailing byte 0x21 -> o_error=11.
